sseg_scan_ctrl: RTL

//  Parametrised N-digit multiplexed seven-segment display driver: hex decode, digit scan, blink, leading-zero blanking, decimal points.

---
 rtl/sseg_scan_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sseg_scan_ctrl.sv
// N-digit multiplexed seven-segment driver: hex decode, digit scan, blink,
// leading-zero blanking and decimal points. Value is snapshotted once per frame.
module sseg_scan_ctrl #(
  parameter int NDIGITS      = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic [NDIGITS-1:0]     dp_in,
  input  logic                   blink_en,
  input  logic                   blank_lz,
  output logic [NDIGITS-1:0]     an,
  output logic [6:0]             seg,
  output logic                   dp,
  output logic                   frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [PW-1:0]          presc_q, presc_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [FW-1:0]          frame_q, frame_d;
  logic                   blink_q, blink_d;
  logic [4*NDIGITS-1:0]   snap_val_q, snap_val_d;
  logic [NDIGITS-1:0]     snap_dp_q, snap_dp_d;
  logic [NDIGITS-1:0]     an_q, an_d;
  logic [6:0]             seg_q, seg_d;
  logic                   dp_q, dp_d;
  logic                   fd_q, fd_d;

  logic                   digit_tick;
  logic                   frame_wrap;
  logic [3:0]             cur_nib;
  logic                   cur_dp;
  logic                   upper_zero;
  logic                   lz_blank;

  assign digit_tick = (presc_q == PRESC_LAST);
  assign frame_wrap = digit_tick && (idx_q == IDX_LAST);

  // NOTE: every always_comb target gets a default first so no path leaves it
  // unassigned; that is what keeps latches from being inferred.
  always_comb begin
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    upper_zero = 1'b1;
    for (int i = 0; i < NDIGITS; i++) begin
      if (IW'(i) == idx_q) begin
        cur_nib = snap_val_q[4*i +: 4];
        cur_dp  = snap_dp_q[i];
      end
      if (i >= int'(idx_q) && snap_val_q[4*i +: 4] != 4'h0) upper_zero = 1'b0;
    end
  end

  assign lz_blank = blank_lz && (idx_q != '0) && upper_zero;

  always_comb begin
    presc_d    = digit_tick ? '0 : presc_q + 1'b1;
    idx_d      = idx_q;
    frame_d    = frame_q;
    blink_d    = blink_q;
    snap_val_d = snap_val_q;
    snap_dp_d  = snap_dp_q;

    if (digit_tick) idx_d = frame_wrap ? '0 : idx_q + 1'b1;

    if (frame_wrap) begin
      snap_val_d = value;
      snap_dp_d  = dp_in;
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end

    // Outputs describe the digit selected by the current idx, one cycle later.
    seg_d = lz_blank ? 7'h7F : hex7(cur_nib);
    dp_d  = lz_blank | ~cur_dp;
    an_d  = (lz_blank || (blink_en && blink_q)) ? '1
                                                 : ~(NDIGITS'(1) << idx_q);
    fd_d  = frame_wrap;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q    <= '0;
      idx_q      <= '0;
      frame_q    <= '0;
      blink_q    <= 1'b0;
      snap_val_q <= '0;
      snap_dp_q  <= '0;
      an_q       <= '1;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
      fd_q       <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      blink_q    <= blink_d;
      snap_val_q <= snap_val_d;
      snap_dp_q  <= snap_dp_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      fd_q       <= fd_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule
